// File: rtl/cpu_out_port.sv
// rtl/cpu_out_port.sv - CPU output port FIFO with overflow tracking
//
// Buffers CPU output writes ({OUT_DEVICE, OUT_DATA}) into a DEPTH-entry FIFO
// and presents the head entry to a peripheral with a valid/ready handshake.
//
// Ports:
//   CPU_clock     in   1     sole clock, rising edge
//   CPU_reset     in   1     synchronous active-high reset
//   OUT_DEVICE    in   16    output device id, 0 = no write this cycle
//   OUT_DATA      in   16    output data paired with OUT_DEVICE
//   dev_valid     out  1     head entry present
//   dev_ready     in   1     peripheral accepts head entry
//   dev_id        out  16    head entry device id (0 when empty)
//   dev_data      out  16    head entry data (0 when empty)
//   fifo_count    out  AW+1  occupancy, 0..DEPTH
//   overflow      out  1     sticky: at least one write dropped
//   drop_count    out  8     dropped writes, saturating at 255
//   overflow_clr  in   1     clears overflow and drop_count

module cpu_out_port #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CPU_clock,
    input  logic          CPU_reset,
    input  logic [15:0]   OUT_DEVICE,
    input  logic [15:0]   OUT_DATA,
    output logic          dev_valid,
    input  logic          dev_ready,
    output logic [15:0]   dev_id,
    output logic [15:0]   dev_data,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic [7:0]    drop_count,
    input  logic          overflow_clr
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf_flag;
    logic [7:0]    drops;

    logic          push_req;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [31:0]   head;

    always_comb begin
        push_req = (OUT_DEVICE != 16'h0000);
        full     = (count == FULL_COUNT);
        pop      = (count != '0) && dev_ready;
        // A full FIFO still takes the write when the head leaves in the same cycle.
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge CPU_clock) begin
        if (!CPU_reset && push_ok) begin
            mem[wr_ptr] <= {OUT_DEVICE, OUT_DATA};
        end
    end

    always_ff @(posedge CPU_clock) begin
        if (CPU_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Clear wins over a drop landing in the same cycle.
    always_ff @(posedge CPU_clock) begin
        if (CPU_reset) begin
            ovf_flag <= 1'b0;
            drops    <= 8'd0;
        end else if (overflow_clr) begin
            ovf_flag <= 1'b0;
            drops    <= 8'd0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end

    always_comb begin
        head       = mem[rd_ptr];
        dev_valid  = (count != '0);
        dev_id     = dev_valid ? head[31:16] : 16'h0000;
        dev_data   = dev_valid ? head[15:0]  : 16'h0000;
        fifo_count = count;
        overflow   = ovf_flag;
        drop_count = drops;
    end

endmodule

// File: tb/tb_cpu_out_port.sv
// tb/tb_cpu_out_port.sv - self-checking bench for cpu_out_port

module tb_cpu_out_port;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CPU_clock = 1'b0;
    logic          CPU_reset;
    logic [15:0]   OUT_DEVICE;
    logic [15:0]   OUT_DATA;
    logic          dev_valid;
    logic          dev_ready;
    logic [15:0]   dev_id;
    logic [15:0]   dev_data;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          overflow_clr;

    int vectors   = 0;
    int miscompares = 0;

    logic [31:0] mq[$];
    logic        m_ovf;
    int          m_drops;

    always #5 CPU_clock = ~CPU_clock;

    cpu_out_port #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CPU_clock    (CPU_clock),
        .CPU_reset    (CPU_reset),
        .OUT_DEVICE   (OUT_DEVICE),
        .OUT_DATA     (OUT_DATA),
        .dev_valid    (dev_valid),
        .dev_ready    (dev_ready),
        .dev_id       (dev_id),
        .dev_data     (dev_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .overflow_clr (overflow_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        v;
        logic [31:0] h;
        v = (mq.size() != 0);
        h = v ? mq[0] : 32'h0;
        chk("dev_valid",  32'(dev_valid),  32'(v));
        chk("dev_id",     32'(dev_id),     32'(h[31:16]));
        chk("dev_data",   32'(dev_data),   32'(h[15:0]));
        chk("fifo_count", 32'(fifo_count), mq.size());
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("drop_count", 32'(drop_count), m_drops);
    endtask

    // One clock: drive on the falling edge, update the queue model, check after the rising edge.
    task automatic cycle(input logic [15:0] dev, input logic [15:0] dat,
                         input logic rdy, input logic clr, input logic rst);
        bit pop;
        bit full;
        @(negedge CPU_clock);
        OUT_DEVICE   = dev;
        OUT_DATA     = dat;
        dev_ready    = rdy;
        overflow_clr = clr;
        CPU_reset    = rst;
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            full = (mq.size() == DEPTH);
            pop  = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (dev != 0) begin
                if (!full || pop) mq.push_back({dev, dat});
                else if (!clr) begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
        end
        @(posedge CPU_clock);
        #1;
        check_all();
    endtask

    initial begin
        OUT_DEVICE = 0; OUT_DATA = 0; dev_ready = 0; overflow_clr = 0; CPU_reset = 1;
        mq.delete(); m_ovf = 0; m_drops = 0;

        // reset state
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // single write
        cycle(16'h0003, 16'hBEEF, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // burst with backpressure, then drain in order
        for (int i = 0; i < 8; i++) cycle(16'h0001, 16'(i), 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);

        // overflow, clear, contents intact
        for (int i = 0; i < 8; i++) cycle(16'h0002, 16'(16'h100 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(16'h0002, 16'(16'h200 + i), 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // clear concurrent with a drop
        cycle(16'h0002, 16'h0300, 0, 0, 0);
        cycle(16'h0002, 16'h0301, 0, 1, 0);
        // drop counter saturation
        for (int i = 0; i < 260; i++) cycle(16'h0004, 16'(i), 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        // full with simultaneous pop and push
        cycle(16'h0005, 16'h00AA, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);

        // randomized wrap-around traffic including idle cycles
        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 9) < 3) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
            cycle(d, 16'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), 0);
        end
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);

        // reset mid-operation with a concurrent write
        for (int i = 0; i < 5; i++) cycle(16'h0006, 16'(i), 0, 0, 0);
        cycle(16'h0006, 16'h0055, 0, 0, 1);
        cycle(16'h0007, 16'h1234, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_out_port.md
CPU_OUT_PORT -- requirements
Module: cpu_out_port

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 3, pointer width = log2(DEPTH).
REQ-003 SHALL have port CPU_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port CPU_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port OUT_DEVICE  input  16  CPU output device id; 0 means no write this cycle.
REQ-006 SHALL have port OUT_DATA  input  16  CPU output data, paired with OUT_DEVICE.
REQ-007 SHALL have port dev_valid  output  1  head entry present.
REQ-008 SHALL have port dev_ready  input  1  peripheral accepts head entry.
REQ-009 SHALL have port dev_id  output  16  head entry device id.
REQ-010 SHALL have port dev_data  output  16  head entry data.
REQ-011 SHALL have port fifo_count  output  AW+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one write dropped.
REQ-013 SHALL have port drop_count  output  8  count of dropped writes, saturating at 255.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow and drop_count.

Function
REQ-015 SHALL sample OUT_DEVICE/OUT_DATA on every CPU_clock rising edge; push request = (OUT_DEVICE != 0). CPU drives these on the falling edge, so they are stable half a cycle before sampling.
REQ-016 SHALL accept one push per cycle, including back-to-back cycles, each a separate entry.
REQ-017 SHALL store {OUT_DEVICE, OUT_DATA} as one 32-bit entry, in arrival order.
REQ-018 SHALL pop the head entry in a cycle where dev_valid && dev_ready; dev_ready is ignored while dev_valid=0.
REQ-019 SHALL set dev_valid = (fifo_count != 0), and drive dev_id/dev_data from the head entry, registered or combinational from storage; no combinational path from OUT_DEVICE to outputs.
REQ-020 SHALL have push-to-valid latency of 1 cycle: push at edge N -> dev_valid=1 with that entry after edge N.
REQ-021 SHALL hold dev_id/dev_data stable while dev_valid=1 and dev_ready=0.
REQ-022 SHALL drive dev_id=0 and dev_data=0 when dev_valid=0.
REQ-023 SHALL, on push with fifo_count<DEPTH, write the entry at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-024 SHALL, on pop, advance rd_ptr modulo DEPTH; pointers wrap from DEPTH-1 to 0.
REQ-025 SHALL update fifo_count: +1 push only, -1 pop only, unchanged for both or neither.
REQ-026 SHALL, when full and a pop occurs in the same cycle, accept the push (count stays DEPTH).
REQ-027 SHALL, when full with no pop, drop the push, set overflow=1, increment drop_count unless 255.
REQ-028 SHALL, when empty, accept a push with no bypass; a same-cycle pop is impossible (dev_valid=0).
REQ-029 SHALL give overflow_clr priority over a same-cycle drop: both flags read 0 after the edge.
REQ-030 SHALL never modify stored entries except by push.

Reset
REQ-031 SHALL, while CPU_reset=1 at an edge, clear wr_ptr, rd_ptr, fifo_count, overflow, drop_count; dev_valid=0, dev_id=0, dev_data=0 after that edge.
REQ-032 SHALL ignore pushes and pops in any cycle where CPU_reset=1, including mid-transfer; pending entries are discarded.
REQ-033 SHALL not require reset of the storage array contents.

Verification
REQ-034 Single write: OUT_DEVICE=0x0003, OUT_DATA=0xBEEF for one cycle, dev_ready=1 -> next cycle dev_valid=1, dev_id=0x0003, dev_data=0xBEEF; following cycle fifo_count=0.
REQ-035 Burst/backpressure: 8 consecutive writes (dev 1, data 0..7), dev_ready=0 -> fifo_count=8, head=data 0 held; raise dev_ready -> data 0..7 emitted in order over 8 cycles.
REQ-036 Overflow: fill 8, dev_ready=0, 3 more writes -> overflow=1, drop_count=3, fifo_count=8; pulse overflow_clr -> both 0, contents intact.
REQ-037 Full simultaneous: full FIFO, dev_ready=1, write data 0x00AA same cycle -> no drop, fifo_count stays 8, 0x00AA emerges 8th after.
REQ-038 Wrap-around: 20 write/drain cycles with random dev_ready -> output sequence equals input sequence; OUT_DEVICE=0 cycles produce no entries.
REQ-039 Reset mid-operation: 5 entries queued, CPU_reset=1 one cycle concurrent with a write -> fifo_count=0, dev_valid=0, overflow=0 after; next write emerges normally.
